jtframe_rom_arb: RTL
====================

JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 The module SHALL have parameter NCH, default 4, giving the number of game ROM slots (legal range 2..8).
REQ-002 The module SHALL have parameter AW, default 22, giving the SDRAM word address width.
REQ-003 The module SHALL have parameter DW, default 32, giving the SDRAM read data width.
REQ-004 The module SHALL have parameter RR, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority (slot 0 highest).
REQ-005 The module SHALL have parameter TOUT, default 63, giving the maximum number of cycles allowed from ack to data_rdy.
REQ-006 The module SHALL have port clk_rom, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-008 The module SHALL have port downloading, input, 1, ROM download in progress.
REQ-009 The module SHALL have port slot_cs, input, NCH, per-slot read request.
REQ-010 The module SHALL have port slot_addr, input, NCH*AW, packed per-slot addresses, with slot i at [i*AW +: AW].
REQ-011 The module SHALL have port slot_ok, output, NCH, per-slot data valid.
REQ-012 The module SHALL have port slot_dout, output, NCH*DW, packed per-slot cached data.
REQ-013 The module SHALL have port sdram_req, output, 1, request to the SDRAM controller.
REQ-014 The module SHALL have port sdram_ack, input, 1, request accepted.
REQ-015 The module SHALL have port sdram_addr, output, AW, request address.
REQ-016 The module SHALL have port data_read, input, DW, SDRAM read data.
REQ-017 The module SHALL have port data_rdy, input, 1, one-cycle strobe marking data_read as valid.

Function
REQ-018 Each slot SHALL hold a cache entry made of valid bit, cached address (AW bits) and cached data (DW bits).
REQ-019 The hit condition SHALL be hit[i] = valid[i] AND cache_addr[i] == slot_addr[i].
REQ-020 slot_ok[i] SHALL equal slot_cs[i] AND hit[i], computed combinationally from registered cache state; slot_dout[i] SHALL equal cache_data[i] at all times.
REQ-021 The pending vector SHALL be pending = slot_cs AND NOT hit.
REQ-022 The FSM SHALL have states IDLE, WAIT_ACK and WAIT_DATA.
REQ-023 IDLE, pending nonzero and downloading low: the arbiter SHALL register the grant index and slot_addr[grant] into sdram_addr, set sdram_req=1 and move to WAIT_ACK on the next edge.
REQ-024 With RR=1, the grant SHALL go to the first pending slot at or after pointer ptr, searching upward with wrap at NCH-1→0.
REQ-025 With RR=0, the grant SHALL go to the lowest-index pending slot.
REQ-026 In WAIT_ACK, sdram_req and sdram_addr SHALL stay constant until sdram_ack is sampled high; then sdram_req SHALL go to 0 on the next edge, the timeout counter SHALL clear, and the state SHALL move to WAIT_DATA.
REQ-027 In WAIT_DATA, when data_rdy is high, the arbiter SHALL write cache_data[grant]=data_read, cache_addr[grant]=latched sdram_addr and valid[grant]=1, then return to IDLE.
REQ-028 On data_rdy in WAIT_DATA with RR=1, the arbiter SHALL set ptr=(grant+1) mod NCH.
REQ-029 The earliest next request SHALL be the cycle after the return to IDLE (no back-to-back issue from WAIT_DATA).
REQ-030 If the timeout counter reaches TOUT in WAIT_DATA without data_rdy, the state SHALL return to IDLE with no cache write and ptr unchanged, so the same slot is retried.
REQ-031 data_rdy SHALL be ignored in IDLE and in WAIT_ACK.
REQ-032 If slot_addr[grant] changes during a transaction, the fill SHALL still use the latched address, so slot_ok stays 0 and a new request follows.
REQ-033 If slot_cs[grant] drops mid-transaction, the transaction SHALL complete and the cache SHALL still fill.
REQ-034 While downloading is high, the arbiter SHALL force the state to IDLE, sdram_req to 0 and all valid bits to 0 on each edge; any in-flight transaction is abandoned, and no grant is issued.
REQ-035 After downloading falls, arbitration SHALL resume on the next cycle.
REQ-036 A write from data_rdy and a clear from downloading in the same cycle SHALL resolve with the clear winning.

Reset
REQ-037 While rst_n is low at a clk_rom edge, the block SHALL set: state=IDLE, sdram_req=0, sdram_addr=0, ptr=0, grant=0, timeout counter=0, all valid=0 and all cache_data=0.
REQ-038 The reset values of REQ-037 SHALL make all slot_ok=0 and all slot_dout=0.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction with no cache write.

Verification
REQ-040 Single fetch: slot1 cs, addr 0x00123 → sdram_req 1 cycle later with sdram_addr 0x00123; ack, then data_rdy with 0xDEADBEEF → slot_ok[1]=1 and slot_dout[1]=0xDEADBEEF; no further request while addr is unchanged.
REQ-041 Round-robin: all 4 slots pending, ptr=0 → grant order 0,1,2,3; with RR=0 and slots 2,3 continuously re-missing → slot 2 is served every time.
REQ-042 Timeout: ack given, data_rdy withheld 63 cycles → return to IDLE, then a re-request for the same address; a late data_rdy arriving in IDLE is ignored.
REQ-043 Address change: slot0 addr 0x10 changes to 0x20 during WAIT_DATA → fill tags 0x10, slot_ok[0]=0, next request uses 0x20.
REQ-044 Downloading: asserted during WAIT_ACK → sdram_req=0 the next cycle and all slot_ok=0; deasserted → pending slots are re-requested.
REQ-045 Reset: rst_n low for 1 cycle during WAIT_DATA → all outputs 0; a data_rdy in the following cycle writes nothing.

Source files
------------

// File: rtl/jtframe_rom_arb.sv
// Arbitrates NCH cached ROM read slots onto one SDRAM read port.
// Each slot keeps one cached word and requests a refill when its address misses.
module jtframe_rom_arb #(
  parameter int NCH  = 4,
  parameter int AW   = 22,
  parameter int DW   = 32,
  parameter int RR   = 1,
  parameter int TOUT = 63
) (
  input  logic              clk_rom,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [NCH-1:0]    slot_cs,
  input  logic [NCH*AW-1:0] slot_addr,
  output logic [NCH-1:0]    slot_ok,
  output logic [NCH*DW-1:0] slot_dout,
  output logic              sdram_req,
  input  logic              sdram_ack,
  output logic [AW-1:0]     sdram_addr,
  input  logic [DW-1:0]     data_read,
  input  logic              data_rdy,
  output logic [1:0]        state_dbg
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [NCH-1:0] valid_q, valid_d;
  logic [AW-1:0] cache_addr_q [NCH];
  logic [AW-1:0] cache_addr_d [NCH];
  logic [DW-1:0] cache_data_q [NCH];
  logic [DW-1:0] cache_data_d [NCH];

  logic [AW-1:0]  addr_a [NCH];
  logic [NCH-1:0] hit;
  logic [NCH-1:0] pending;
  logic [GW-1:0]  gnt_c;
  logic [GW-1:0]  ptr_next;
  int             base_c;
  int             idx_c;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    assign addr_a[i]               = slot_addr[i*AW +: AW];
    assign hit[i]                  = valid_q[i] && (cache_addr_q[i] == addr_a[i]);
    assign slot_dout[i*DW +: DW]   = cache_data_q[i];
  end

  assign pending    = slot_cs & ~hit;
  assign slot_ok    = slot_cs & hit;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign state_dbg  = state_q;
  assign ptr_next   = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + 1'b1;

  // Search downward so the candidate nearest the base (smallest offset) wins.
  always_comb begin
    gnt_c  = '0;
    base_c = (RR != 0) ? int'(ptr_q) : 0;
    idx_c  = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx_c = (base_c + k) % NCH;
      if (pending[idx_c]) gnt_c = GW'(idx_c);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    req_d        = req_q;
    addr_d       = addr_q;
    tout_d       = tout_q;
    valid_d      = valid_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    if (downloading) begin
      // Download rewrites ROM contents: drop everything, including a fill in the same cycle.
      state_d = ST_IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending) begin
            grant_d = gnt_c;
            addr_d  = addr_a[gnt_c];
            req_d   = 1'b1;
            state_d = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            tout_d  = '0;
            state_d = ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (data_rdy) begin
            cache_data_d[grant_q] = data_read;
            cache_addr_d[grant_q] = addr_q;
            valid_d[grant_q]      = 1'b1;
            if (RR != 0) ptr_d = ptr_next;
            state_d = ST_IDLE;
          end else if (tout_q == TW'(TOUT)) begin
            state_d = ST_IDLE;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      tout_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cache_addr_q[i] <= '0;
        cache_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      tout_q       <= tout_d;
      valid_q      <= valid_d;
      cache_addr_q <= cache_addr_d;
      cache_data_q <= cache_data_d;
    end
  end

endmodule
